fft_bitrev_loader: RTL and testbench
====================================

Name: fft_bitrev_loader

Overview:
- Sits directly downstream of the FFT test-data generator and directly upstream of the first butterfly stage.
- Captures one frame of N = 2^LAYER complex samples, framed by the generator's start/valid/over strobes.
- Writes each frame into a ping-pong buffer at bit-reversed addresses.
- Streams each completed frame out in natural address order over a valid/ready handshake, so the FFT core receives bit-reversed input order.

Parameters:
- LAYER, 3, log2 of frame length; N = 1<<LAYER; legal range 1..10.
- DW, 32, width of each real and imaginary sample word.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_real  in  DW  real sample from generator.
- in_img  in  DW  imaginary sample from generator.
- in_valid  in  1  sample qualifier.
- in_start  in  1  one-cycle pulse, first cycle of a frame.
- in_over  in  1  one-cycle pulse, frame end marker.
- out_real  out  DW  real sample to FFT core.
- out_img  out  DW  imaginary sample to FFT core.
- out_valid  out  1  output sample valid.
- out_ready  in  1  FFT core accepts the sample when out_valid&&out_ready.
- out_first  out  1  high with the sample at natural index 0.
- out_last  out  1  high with the sample at natural index N-1.
- err_drop  out  1  sticky: a frame start arrived with no free bank.
- err_short  out  1  sticky: in_over arrived before N samples were captured.
- frame_cnt  out  16  number of frames fully delivered; wraps at 2^16.

Behaviour:
- Reset (rst=0, async) clears all outputs and state to 0:
  - out_* = 0, out_valid = 0, err_* = 0, frame_cnt = 0.
  - Both banks empty, wbank = rbank = 0, both FSMs idle.
  - Reset mid-frame discards all buffered data.
- Storage: 2 banks x N entries x 2*DW bits. Each bank has a registered full flag.
- Write FSM, W_IDLE -> W_FILL:
  - In W_IDLE, in_start=1 and bank[wbank] not full -> W_FILL with wcnt=0. The start cycle's sample is captured if in_valid=1 on that cycle.
  - In W_IDLE, in_start=1 and bank[wbank] full -> set err_drop; stay in W_IDLE; ignore the frame.
  - In W_FILL (including the entry cycle), each in_valid=1 writes {in_real,in_img} to bank[wbank][bitrev(wcnt)], then wcnt++.
    - bitrev reverses the LAYER LSBs, e.g. N=8: 1->4, 3->6.
  - On the write with wcnt=N-1: set full[wbank], toggle wbank, return to W_IDLE.
  - in_valid=0 cycles are skipped and wcnt holds.
  - in_over in W_FILL with wcnt<N: set err_short, discard the partial frame (full stays 0), return to W_IDLE.
  - in_over coinciding with the N-th write: the frame completes normally.
  - in_start in W_FILL: abort the partial frame, set err_short, restart with wcnt=0, and capture the current sample if valid.
  - in_over outside W_FILL is ignored.
  - Samples with in_valid=1 in W_IDLE are ignored.
- Read FSM, R_IDLE -> R_STREAM:
  - In R_IDLE, full[rbank]=1 -> R_STREAM, rcnt=0.
  - out_valid rises exactly 2 cycles after the edge that set full: 1 cycle for the flag, 1 for the registered RAM read.
  - Data order is natural address rcnt = 0..N-1.
  - out_first = (rcnt==0) && out_valid; out_last = (rcnt==N-1) && out_valid.
  - Stall: while out_valid=1 and out_ready=0, out_real, out_img, out_first and out_last hold stable. out_valid is never withdrawn without acceptance.
  - After acceptance, the next sample is presented on the following cycle: back-to-back throughput of 1 sample/clock with out_ready held high (prefetch or skid register required).
  - When the last sample is accepted: clear full[rbank], toggle rbank, frame_cnt++, return to R_IDLE. If the other bank is already full, out_valid may re-rise after the 2-cycle read latency.
- Simultaneous events:
  - A write completing into one bank while the other bank is being read proceeds independently.
  - The full flag is tested as registered. An in_start in the same cycle as the final read acceptance of that bank sees it full and is dropped (err_drop).
- err_drop and err_short clear only on reset.
- Bit-reversal of index 0 and N-1 maps to itself.

Test Plan:
- LAYER=3; start+valid with in_real=0..7, in_img=0, out_ready=1 -> out_real 0,4,2,6,1,5,3,7. out_first on the first sample, out_last on the eighth. out_valid rises 2 cycles after the 8th write. frame_cnt=1.
- LAYER=2; valid toggling 2-on/2-off, in_real=10,11,12,13 -> out_real 10,12,11,13. wcnt holds during gaps.
- LAYER=3; out_ready held 0 for 5 cycles at the third sample -> out_real=2 is held stable for 5 cycles, no sample is lost, and the full sequence completes.
- LAYER=2; out_ready=0; three consecutive complete frames -> frames 1 and 2 are buffered, the third start sets err_drop=1. After releasing out_ready, exactly 8 samples are output and frame_cnt=2.
- LAYER=3; in_over after 5 samples -> err_short=1, no out_valid. The next full frame streams correctly.
- Assert rst=0 mid-stream (sample 3 of 8) -> outputs are 0 immediately, asynchronously. After release, no residual output and frame_cnt=0.

Source files
------------

// File: rtl/fft_bitrev_loader_if.sv
// Sample stream bundle between the test-data generator, the bit-reversal loader and the FFT core.
// The master modport is the generator/core side, the slave modport is the loader.
interface fft_bitrev_loader_if #(
  parameter int unsigned DW = 32
) ();
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_img;
  logic          in_valid;
  logic          in_start;
  logic          in_over;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;

  modport master (
    output in_real, in_img, in_valid, in_start, in_over, out_ready,
    input  out_real, out_img, out_valid, out_first, out_last
  );

  modport slave (
    input  in_real, in_img, in_valid, in_start, in_over, out_ready,
    output out_real, out_img, out_valid, out_first, out_last
  );
endinterface

// File: rtl/fft_bitrev_loader.sv
// Captures generator frames into a ping-pong buffer at bit-reversed addresses and
// streams each completed frame out in natural order over valid/ready.
module fft_bitrev_loader #(
  parameter int unsigned LAYER = 3,
  parameter int unsigned DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_bitrev_loader_if.slave   bus,
  output logic                 err_drop,
  output logic                 err_short,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned N  = 1 << LAYER;
  localparam int unsigned AW = LAYER + 1;
  localparam int unsigned SW = 2 * DW;
  localparam logic [LAYER-1:0] LAST_IDX = LAYER'(N - 1);
  localparam logic [LAYER-1:0] ZERO_IDX = '0;

  typedef enum logic { W_IDLE, W_FILL }   wstate_t;
  typedef enum logic { R_IDLE, R_STREAM } rstate_t;

  wstate_t          wstate;
  rstate_t          rstate;
  logic [LAYER-1:0] wcnt;
  logic [LAYER-1:0] fcnt;
  logic             wbank;
  logic             rbank;
  logic [1:0]       full;
  logic             fetch_done;

  logic             wr_en_c;
  logic [AW-1:0]    wr_addr_c;
  logic             set_full_c;
  logic             clr_full_c;
  logic             rd_load_c;
  logic [SW-1:0]    rd_word_c;

  logic [SW-1:0]    mem [2*N];

  function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] a);
    logic [LAYER-1:0] r;
    for (int i = 0; i < LAYER; i++) r[i] = a[LAYER-1-i];
    return r;
  endfunction

  // Write-side decode: memory write strobe/address and frame completion
  always_comb begin
    wr_en_c    = 1'b0;
    wr_addr_c  = {wbank, bitrev(wcnt)};
    set_full_c = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (bus.in_start && !full[wbank] && bus.in_valid) begin
          wr_en_c   = 1'b1;
          wr_addr_c = {wbank, ZERO_IDX};
        end
      end
      W_FILL: begin
        if (bus.in_start) begin
          wr_en_c   = bus.in_valid;
          wr_addr_c = {wbank, ZERO_IDX};
        end else begin
          wr_en_c    = bus.in_valid;
          set_full_c = bus.in_valid && (wcnt == LAST_IDX);
        end
      end
      default: ;
    endcase
  end

  assign clr_full_c = (rstate == R_STREAM) && bus.out_valid && bus.out_ready && bus.out_last;
  assign rd_load_c  = (rstate == R_STREAM) && !fetch_done && (!bus.out_valid || bus.out_ready);
  assign rd_word_c  = mem[{rbank, fcnt}];

  // Sample storage; contents are meaningless until the bank's full flag is set
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= {bus.in_real, bus.in_img};
  end

  // Bank ownership: writer sets, reader clears; they never target the same bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
    end else begin
      if (set_full_c) full[wbank] <= 1'b1;
      if (clr_full_c) full[rbank] <= 1'b0;
    end
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate    <= W_IDLE;
      wcnt      <= '0;
      wbank     <= 1'b0;
      err_drop  <= 1'b0;
      err_short <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (bus.in_start) begin
            if (full[wbank]) begin
              err_drop <= 1'b1;
            end else begin
              wstate <= W_FILL;
              wcnt   <= bus.in_valid ? LAYER'(1) : ZERO_IDX;
            end
          end
        end
        W_FILL: begin
          if (bus.in_start) begin
            err_short <= 1'b1;
            wcnt      <= bus.in_valid ? LAYER'(1) : ZERO_IDX;
          end else if (set_full_c) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
            wbank  <= ~wbank;
          end else if (bus.in_over) begin
            err_short <= 1'b1;
            wstate    <= W_IDLE;
            wcnt      <= '0;
          end else if (bus.in_valid) begin
            wcnt <= wcnt + LAYER'(1);
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM; the output register doubles as the RAM read register and holds under stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate        <= R_IDLE;
      rbank         <= 1'b0;
      fcnt          <= '0;
      fetch_done    <= 1'b0;
      frame_cnt     <= '0;
      bus.out_real  <= '0;
      bus.out_img   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (full[rbank]) begin
            rstate     <= R_STREAM;
            fcnt       <= '0;
            fetch_done <= 1'b0;
          end
        end
        R_STREAM: begin
          if (rd_load_c) begin
            bus.out_real  <= rd_word_c[SW-1:DW];
            bus.out_img   <= rd_word_c[DW-1:0];
            bus.out_valid <= 1'b1;
            bus.out_first <= (fcnt == ZERO_IDX);
            bus.out_last  <= (fcnt == LAST_IDX);
            fcnt          <= fcnt + LAYER'(1);
            if (fcnt == LAST_IDX) fetch_done <= 1'b1;
          end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            if (bus.out_last) begin
              rstate    <= R_IDLE;
              rbank     <= ~rbank;
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed-sequence bench for fft_bitrev_loader (LAYER=3) with randomized sample data
// checked against a frame-level reference queue.
module tb_fft_bitrev_loader;

  localparam int unsigned LAYER = 3;
  localparam int unsigned N     = 1 << LAYER;
  localparam int unsigned DW    = 32;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit            first;
    bit            last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_drop;
  logic        err_short;
  logic [15:0] frame_cnt;

  fft_bitrev_loader_if #(.DW(DW)) bus ();

  fft_bitrev_loader #(.LAYER(LAYER), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .err_drop  (err_drop),
    .err_short (err_short),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] log_q[$];
  int            accepted_frames  = 0;
  int            frames_delivered = 0;
  int            pos              = 0;
  int            stall_seen       = 0;
  bit            stall_prev       = 1'b0;
  logic [DW-1:0] prev_re, prev_im;
  logic          prev_first, prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int bitrev(input int x);
    int r = 0;
    for (int b = 0; b < LAYER; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  // Output monitor: handshake scoreboard plus stall stability
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (stall_prev) begin
        stall_seen++;
        check("stall_valid", bus.out_valid, 1);
        check("stall_real",  bus.out_real,  prev_re);
        check("stall_img",   bus.out_img,   prev_im);
        check("stall_first", bus.out_first, prev_first);
        check("stall_last",  bus.out_last,  prev_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", bus.out_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_real",  bus.out_real,  e.re);
          check("out_img",   bus.out_img,   e.im);
          check("out_first", bus.out_first, e.first);
          check("out_last",  bus.out_last,  e.last);
          log_q.push_back(bus.out_real);
          if (e.last) begin
            frames_delivered++;
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_re    = bus.out_real;
      prev_im    = bus.out_img;
      prev_first = bus.out_first;
      prev_last  = bus.out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Drive one frame; complete accepted frames enter the reference queue in natural output order
  task automatic drive_frame(input int nsamp, input bit gaps, input bit over_end,
                             input bit rnd, input int base);
    exp_t fr[N];
    bit   will_accept;
    will_accept = (accepted_frames - frames_delivered) < 2;
    for (int k = 0; k < nsamp; k++) begin
      @(posedge clk); #1;
      bus.in_start = (k == 0);
      bus.in_valid = 1'b1;
      bus.in_real  = rnd ? $urandom() : 32'(base + k);
      bus.in_img   = rnd ? $urandom() : 32'd0;
      fr[k].re     = bus.in_real;
      fr[k].im     = bus.in_img;
      if (gaps && (k % 2 == 1) && (k != nsamp - 1)) begin
        repeat (2) begin
          @(posedge clk); #1;
          bus.in_start = 1'b0;
          bus.in_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_over  = over_end;
    if (over_end) begin
      @(posedge clk); #1;
      bus.in_over = 1'b0;
    end
    if (nsamp == N && will_accept) begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        e.re    = fr[bitrev(i)].re;
        e.im    = fr[bitrev(i)].im;
        e.first = (i == 0);
        e.last  = (i == N - 1);
        exp_q.push_back(e);
      end
      accepted_frames++;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_pos(input int target, output bit found);
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(posedge clk); #1;
      if (bus.out_valid && pos == target) found = 1'b1;
    end
  endtask

  initial begin
    logic [DW-1:0] want [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    bit found;

    rst           = 1'b0;
    bus.in_real   = '0;
    bus.in_img    = '0;
    bus.in_valid  = 1'b0;
    bus.in_start  = 1'b0;
    bus.in_over   = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_real",  bus.out_real,  0);
    check("rst_out_img",   bus.out_img,   0);
    check("rst_out_first", bus.out_first, 0);
    check("rst_out_last",  bus.out_last,  0);
    check("rst_err_drop",  err_drop,      0);
    check("rst_err_short", err_short,     0);
    check("rst_frame_cnt", frame_cnt,     0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Ramp 0..7: natural-order output must be the bit-reversed ramp, two-cycle latency
    bus.out_ready = 1'b1;
    log_q.delete();
    drive_frame(N, 1'b0, 1'b0, 1'b0, 0);
    check("lat_edge0_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge1_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", bus.out_valid, 1);
    check("lat_edge2_first", bus.out_first, 1);
    wait_drain();
    check("ramp_count", log_q.size(), N);
    for (int i = 0; i < N; i++)
      if (i < log_q.size()) check("ramp_order", log_q[i], want[i]);
    check("ramp_frame_cnt", frame_cnt, 1);

    // Valid gaps 2-on/2-off with random data
    log_q.delete();
    drive_frame(N, 1'b1, 1'b0, 1'b1, 0);
    wait_drain();
    check("gap_count", log_q.size(), N);
    check("gap_frame_cnt", frame_cnt, 2);

    // Backpressure: out_ready low for 5 cycles at the third sample
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    wait_pos(2, found);
    check("stall_point_found", found, 1);
    bus.out_ready = 1'b0;
    stall_seen = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_hold_valid", bus.out_valid, 1);
      if (exp_q.size() != 0) check("stall_hold_data", bus.out_real, exp_q[0].re);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check("stall_cycles", stall_seen, 5);
    check("stall_frame_cnt", frame_cnt, 3);

    // Overflow: three frames with the core stalled, third must be dropped
    bus.out_ready = 1'b0;
    log_q.delete();
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    check("ovf_no_drop_yet", err_drop, 0);
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    check("ovf_err_drop", err_drop, 1);
    bus.out_ready = 1'b1;
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    check("ovf_count", log_q.size(), 2 * N);
    check("ovf_idle_after", bus.out_valid, 0);
    check("ovf_frame_cnt", frame_cnt, 5);

    // Short frame: in_over after 5 samples, then a normal frame
    log_q.delete();
    check("short_err_before", err_short, 0);
    drive_frame(5, 1'b0, 1'b1, 1'b1, 0);
    check("short_err_short", err_short, 1);
    repeat (6) begin
      @(negedge clk);
      check("short_no_valid", bus.out_valid, 0);
    end
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    wait_drain();
    check("short_next_count", log_q.size(), N);
    check("short_frame_cnt", frame_cnt, 6);

    // Restart: in_start mid-fill aborts the partial frame and refills from index 0
    drive_frame(3, 1'b0, 1'b0, 1'b1, 0);
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    wait_drain();
    check("restart_frame_cnt", frame_cnt, 7);

    // Asynchronous reset while the fourth sample is on the output
    drive_frame(N, 1'b0, 1'b0, 1'b1, 0);
    wait_pos(3, found);
    check("reset_point_found", found, 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    accepted_frames  = 0;
    frames_delivered = 0;
    pos              = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_real",  bus.out_real,  0);
    check("arst_out_img",   bus.out_img,   0);
    check("arst_out_first", bus.out_first, 0);
    check("arst_out_last",  bus.out_last,  0);
    check("arst_frame_cnt", frame_cnt,     0);
    check("arst_err_drop",  err_drop,      0);
    check("arst_err_short", err_short,     0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_valid",  bus.out_valid, 0);
    check("post_rst_frame_cnt", frame_cnt,     0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
